sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 29 ++
 rtl/sync_fifo_flags.sv | 113 +++++++++++
 tb/tb_sync_fifo_flags.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the error-flag encoding used by sync_fifo_flags
// and later FIFO variants.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_SIZE = 8;
    localparam int unsigned FIFO_ADDR_SIZE = 4;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    localparam fifo_err_t FIFO_ERR_NONE = '0;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_SIZE storage: one synchronous write port, one asynchronous read
// port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE = FIFO_DATA_SIZE,
    parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE
)(
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0] rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered full/empty/almost flags, an occupancy count
// and sticky overflow/underflow flags; FWFT selects registered or fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = FIFO_DATA_SIZE,
    parameter int unsigned ADDR_SIZE  = FIFO_ADDR_SIZE,
    parameter int unsigned AFULL_LVL  = (2 ** ADDR_SIZE) - 2,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter bit          FWFT       = 1'b0
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_inc,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd_inc,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 wr_full,
    output logic                 wr_afull,
    output logic                 rd_empty,
    output logic                 rd_aempty,
    output logic [ADDR_SIZE:0]   count,
    output logic                 wr_overflow,
    output logic                 rd_underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] ONE        = {{ADDR_SIZE{1'b0}}, 1'b1};
    localparam logic [ADDR_SIZE:0] MSB_ONLY   = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0] AFULL_CNT  = AFULL_LVL[ADDR_SIZE:0];
    localparam logic [ADDR_SIZE:0] AEMPTY_CNT = AEMPTY_LVL[ADDR_SIZE:0];

    if (!(AEMPTY_LVL >= 1 && AEMPTY_LVL < AFULL_LVL && AFULL_LVL <= DEPTH - 1)) begin : g_bad_levels
        $error("sync_fifo_flags: need 1 <= AEMPTY_LVL < AFULL_LVL <= DEPTH-1");
    end

    logic [ADDR_SIZE:0]   wr_ptr, rd_ptr;
    logic [ADDR_SIZE:0]   wr_ptr_next, rd_ptr_next, count_next;
    logic                 wr_acc, rd_acc;
    logic [DATA_SIZE-1:0] mem_rdata;
    fifo_err_t            err;

    assign wr_acc = wr_inc & ~wr_full;
    assign rd_acc = rd_inc & ~rd_empty;

    always_comb begin
        wr_ptr_next = wr_acc ? wr_ptr + ONE : wr_ptr;
        rd_ptr_next = rd_acc ? rd_ptr + ONE : rd_ptr;
        count_next  = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // Flags are computed from the post-edge pointers/count so they move with count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_full   <= 1'b0;
            wr_afull  <= 1'b0;
            rd_empty  <= 1'b1;
            rd_aempty <= 1'b1;
            err       <= FIFO_ERR_NONE;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            count         <= count_next;
            wr_full       <= (wr_ptr_next ^ rd_ptr_next) == MSB_ONLY;
            rd_empty      <= wr_ptr_next == rd_ptr_next;
            wr_afull      <= count_next >= AFULL_CNT;
            rd_aempty     <= count_next <= AEMPTY_CNT;
            err.overflow  <= err.overflow | (wr_inc & wr_full);
            err.underflow <= err.underflow | (rd_inc & rd_empty);
        end
    end

    assign wr_overflow  = err.overflow;
    assign rd_underflow = err.underflow;

    fifo_mem #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[ADDR_SIZE-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[ADDR_SIZE-1:0]),
        .rd_data (mem_rdata)
    );

    if (FWFT) begin : g_fwft
        // Head word is visible combinationally; forced to zero while empty.
        assign rd_data = rd_empty ? '0 : mem_rdata;
    end else begin : g_reg
        logic [DATA_SIZE-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_acc) begin
                rd_q <= mem_rdata;
            end
        end

        assign rd_data = rd_q;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed and randomized checks of sync_fifo_flags (registered-read and FWFT
// instances driven together) against a queue-based reference model.
module tb_sync_fifo_flags;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_inc = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_inc = 1'b0;

    logic [7:0] rd_data_r, rd_data_f;
    logic       wr_full_r, wr_afull_r, rd_empty_r, rd_aempty_r, ovf_r, unf_r;
    logic       wr_full_f, wr_afull_f, rd_empty_f, rd_aempty_f, ovf_f, unf_f;
    logic [4:0] count_r, count_f;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_rd;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1'b0)) dut_r (
        .clk(clk), .rst(rst), .wr_inc(wr_inc), .wr_data(wr_data), .rd_inc(rd_inc),
        .rd_data(rd_data_r), .wr_full(wr_full_r), .wr_afull(wr_afull_r),
        .rd_empty(rd_empty_r), .rd_aempty(rd_aempty_r), .count(count_r),
        .wr_overflow(ovf_r), .rd_underflow(unf_r)
    );

    sync_fifo_flags #(.DATA_SIZE(8), .ADDR_SIZE(4), .FWFT(1'b1)) dut_f (
        .clk(clk), .rst(rst), .wr_inc(wr_inc), .wr_data(wr_data), .rd_inc(rd_inc),
        .rd_data(rd_data_f), .wr_full(wr_full_f), .wr_afull(wr_afull_f),
        .rd_empty(rd_empty_f), .rd_aempty(rd_aempty_f), .count(count_f),
        .wr_overflow(ovf_f), .rd_underflow(unf_f)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count",      32'(count_r),     32'(n));
        chk("wr_full",    32'(wr_full_r),   32'(n == DEPTH));
        chk("wr_afull",   32'(wr_afull_r),  32'(n >= DEPTH - 2));
        chk("rd_empty",   32'(rd_empty_r),  32'(n == 0));
        chk("rd_aempty",  32'(rd_aempty_r), 32'(n <= 2));
        chk("overflow",   32'(ovf_r),       32'(m_ovf));
        chk("underflow",  32'(unf_r),       32'(m_unf));
        chk("rd_data",    32'(rd_data_r),   32'(m_rd));
        chk("count_f",    32'(count_f),     32'(n));
        chk("wr_full_f",  32'(wr_full_f),   32'(n == DEPTH));
        chk("wr_afull_f", 32'(wr_afull_f),  32'(n >= DEPTH - 2));
        chk("rd_empty_f", 32'(rd_empty_f),  32'(n == 0));
        chk("rd_aempty_f",32'(rd_aempty_f), 32'(n <= 2));
        chk("overflow_f", 32'(ovf_f),       32'(m_ovf));
        chk("underflow_f",32'(unf_f),       32'(m_unf));
        if (n != 0) begin
            chk("rd_data_fwft", 32'(rd_data_f), 32'(q[0]));
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge, compare 1 time unit later.
    task automatic step(input bit r, input bit wi, input logic [7:0] wd, input bit ri);
        bit full, empty;
        logic [7:0] head;
        @(negedge clk);
        rst = r; wr_inc = wi; wr_data = wd; rd_inc = ri;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd  = '0;
        end else begin
            full  = (q.size() == DEPTH);
            empty = (q.size() == 0);
            if (wi && full)  m_ovf = 1'b1;
            if (ri && empty) m_unf = 1'b1;
            if (ri && !empty) begin
                head = q.pop_front();
                m_rd = head;
            end
            if (wi && !full) q.push_back(wd);
        end
        #1;
        check_all();
    endtask

    initial begin
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Fill with 0x01..0x10, then one write too many.
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("full_after_16", 32'(wr_full_r), 32'd1);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        chk("ovf_after_17th", 32'(ovf_r), 32'd1);

        // Full with simultaneous request: read accepted, write rejected.
        step(1'b0, 1'b1, 8'h99, 1'b1);
        chk("full_both_count", 32'(count_r), 32'(DEPTH - 1));

        // Drain; rd_data follows 0x01.. one cycle after each read.
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("underflow_read", 32'(unf_r), 32'd1);

        // Empty with simultaneous request: write accepted, read rejected.
        step(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("empty_both_count", 32'(count_r), 32'd1);

        // Hold count at 5 through 40 read+write cycles so pointers wrap.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'($urandom), 1'b1);
        chk("steady_count", 32'(count_r), 32'd5);

        // FWFT: head word appears without a read request.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hA5, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fwft_a5", 32'(rd_data_f), 32'hA5);

        // Set both sticky flags, settle at count 9, then reset for one cycle.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_reset_count", 32'(count_r), 32'd9);
        step(1'b1, 1'b1, 8'h55, 1'b1);
        chk("reset_count", 32'(count_r), 32'd0);
        chk("reset_flags", 32'({ovf_r, unf_r, rd_empty_r}), 32'b001);

        // Randomized traffic with shifting read/write bias and rare resets.
        for (int i = 0; i < 600; i++) begin
            int wbias;
            wbias = ((i / 100) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < wbias,
                 8'($urandom),
                 $urandom_range(0, 99) < (100 - wbias));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
